mem_port_arbiter: RTL and testbench

- Shares the single 128-bit main-memory port between the instruction cache (read-only, line fill) and the data cache (line fill and write-back).
- Sits between both caches' mem_* interfaces and the memory model or bus.
- Registers each granted request, holds it stable on the memory side until mem_ready, captures the returned line, and hands a one-cycle ready pulse back to the owning cache.
- Round-robin arbitration prevents starvation.

---
 rtl/mem_port_arbiter.sv | 135 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one 128-bit line port between the I-cache (fills)
// and the D-cache (fills and write-backs); one transaction in flight at a time.
module mem_port_arbiter #(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_mem_read,
  input  logic [ADDR_W-1:0] i_mem_addr,
  output logic [DATA_W-1:0] i_mem_rdata,
  output logic              i_mem_ready,
  input  logic              d_mem_read,
  input  logic              d_mem_write,
  input  logic [ADDR_W-1:0] d_mem_addr,
  input  logic [DATA_W-1:0] d_mem_wdata,
  output logic [DATA_W-1:0] d_mem_rdata,
  output logic              d_mem_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [1:0]        dbg_state_o
);

  // Handshake: a cache holds its request level until its *_mem_ready pulse and
  // drops it the cycle after; the memory holds mem_ready off until the strobed
  // op is done, and the strobes stay stable through the mem_ready cycle.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                last_d_q, last_d_d;
  logic                owner_d_q, owner_d_d;
  logic                op_write_q, op_write_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
  logic                mem_read_q, mem_read_d;
  logic                mem_write_q, mem_write_d;
  logic                i_ready_q, i_ready_d;
  logic                d_ready_q, d_ready_d;
  logic                req_i, req_d, grant_d;

  assign req_i = i_mem_read;
  assign req_d = d_mem_read | d_mem_write;
  // D wins when it is the only requester or when I was granted last.
  assign grant_d = req_d & (~req_i | ~last_d_q);

  always_comb begin
    state_d    = state_q;
    last_d_d   = last_d_q;
    owner_d_d  = owner_d_q;
    op_write_d = op_write_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    i_rdata_d  = i_rdata_q;
    d_rdata_d  = d_rdata_q;
    case (state_q)
      S_IDLE: begin
        if (req_i | req_d) begin
          state_d    = S_BUSY;
          owner_d_d  = grant_d;
          last_d_d   = grant_d;
          op_write_d = grant_d & d_mem_write;
          addr_d     = grant_d ? d_mem_addr : i_mem_addr;
          wdata_d    = (grant_d & d_mem_write) ? d_mem_wdata : '0;
        end
      end
      S_BUSY: begin
        if (mem_ready) begin
          state_d = S_RESP;
          if (!op_write_q) begin
            if (owner_d_q) d_rdata_d = mem_rdata;
            else           i_rdata_d = mem_rdata;
          end
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Registered outputs are computed from the next state so they line up with it.
    mem_read_d  = (state_d == S_BUSY) & ~op_write_d;
    mem_write_d = (state_d == S_BUSY) & op_write_d;
    i_ready_d   = (state_d == S_RESP) & ~owner_d_d;
    d_ready_d   = (state_d == S_RESP) & owner_d_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      last_d_q    <= 1'b1;
      owner_d_q   <= 1'b0;
      op_write_q  <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      i_ready_q   <= 1'b0;
      d_ready_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_d_q    <= last_d_d;
      owner_d_q   <= owner_d_d;
      op_write_q  <= op_write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      i_ready_q   <= i_ready_d;
      d_ready_q   <= d_ready_d;
    end
  end

  assign mem_read    = mem_read_q;
  assign mem_write   = mem_write_q;
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;
  assign i_mem_rdata = i_rdata_q;
  assign d_mem_rdata = d_rdata_q;
  assign i_mem_ready = i_ready_q;
  assign d_mem_ready = d_ready_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: inputs driven and outputs sampled on the
// falling edge; the bench plays the memory with a fixed per-transaction latency.
module tb_mem_port_arbiter;
  localparam int AW = 28;
  localparam int DW = 128;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_mem_read = 1'b0;
  logic [AW-1:0] i_mem_addr = '0;
  logic [DW-1:0] i_mem_rdata;
  logic          i_mem_ready;
  logic          d_mem_read = 1'b0;
  logic          d_mem_write = 1'b0;
  logic [AW-1:0] d_mem_addr = '0;
  logic [DW-1:0] d_mem_wdata = '0;
  logic [DW-1:0] d_mem_rdata;
  logic          d_mem_ready;
  logic          mem_read;
  logic          mem_write;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_ready = 1'b0;
  logic [1:0]    dbg_state;

  int n_checks = 0;
  int n_fail = 0;
  logic [DW-1:0] exp_i_rdata = '0;
  logic [DW-1:0] exp_d_rdata = '0;
  logic [AW-1:0] exp_q[$];

  // Observations returned by the memory driver.
  int            o_nrd, o_nwr, o_gap;
  logic [AW-1:0] o_addr;
  logic [DW-1:0] o_wdata;
  bit            o_stable, o_to;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_mem_read(i_mem_read), .i_mem_addr(i_mem_addr),
    .i_mem_rdata(i_mem_rdata), .i_mem_ready(i_mem_ready),
    .d_mem_read(d_mem_read), .d_mem_write(d_mem_write),
    .d_mem_addr(d_mem_addr), .d_mem_wdata(d_mem_wdata),
    .d_mem_rdata(d_mem_rdata), .d_mem_ready(d_mem_ready),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .dbg_state_o(dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Memory driver: waits (bounded) for a strobe, answers after lat strobe
  // cycles, and returns at the falling edge of the RESP cycle.
  task automatic mem_respond(input int lat, input logic [DW-1:0] rd);
    int wait_cnt = 0;
    o_nrd = 0; o_nwr = 0; o_gap = 0; o_stable = 1'b1; o_to = 1'b0;
    o_addr = '0; o_wdata = '0;
    @(negedge clk);
    while (!(mem_read || mem_write) && wait_cnt < 50) begin
      wait_cnt++;
      @(negedge clk);
    end
    o_gap = wait_cnt;
    if (wait_cnt >= 50) begin
      o_to = 1'b1;
      return;
    end
    o_addr = mem_addr;
    o_wdata = mem_wdata;
    for (int k = 1; k <= lat; k++) begin
      if (mem_read) o_nrd++;
      if (mem_write) o_nwr++;
      if (mem_addr !== o_addr || mem_wdata !== o_wdata) o_stable = 1'b0;
      if (k == lat) begin
        mem_ready = 1'b1;
        mem_rdata = rd;
      end
      @(negedge clk);
    end
    mem_ready = 1'b0;
    mem_rdata = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({mem_read, mem_write, i_mem_ready, d_mem_ready} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_strobes: got %b expected 0000", {mem_read, mem_write, i_mem_ready, d_mem_ready});
    end
    n_checks++;
    if (mem_addr !== 28'h0 || mem_wdata !== 128'h0) begin
      n_fail++; $display("FAIL reset_mem_bus: got addr %h wdata %h expected 0", mem_addr, mem_wdata);
    end
    n_checks++;
    if (i_mem_rdata !== 128'h0 || d_mem_rdata !== 128'h0) begin
      n_fail++; $display("FAIL reset_rdata: got i %h d %h expected 0", i_mem_rdata, d_mem_rdata);
    end
    n_checks++;
    if (dbg_state !== 2'd0) begin
      n_fail++; $display("FAIL reset_state: got %0d expected 0", dbg_state);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_i_only();
    logic [DW-1:0] rd = 128'hDEADBEEF_00112233_44556677_8899AABB;
    i_mem_addr = 28'h0000010;
    i_mem_read = 1'b1;
    mem_respond(3, rd);
    i_mem_read = 1'b0;
    exp_i_rdata = rd;
    n_checks++;
    if (o_to || o_nrd != 3 || o_nwr != 0 || !o_stable) begin
      n_fail++; $display("FAIL i_only_strobe: got to=%0d rd=%0d wr=%0d stable=%0d expected 0 3 0 1", o_to, o_nrd, o_nwr, o_stable);
    end
    n_checks++;
    if (o_addr !== 28'h0000010) begin
      n_fail++; $display("FAIL i_only_addr: got %h expected 0000010", o_addr);
    end
    n_checks++;
    if ({i_mem_ready, d_mem_ready, mem_read} !== 3'b100) begin
      n_fail++; $display("FAIL i_only_resp: got i/d/rd %b expected 100", {i_mem_ready, d_mem_ready, mem_read});
    end
    n_checks++;
    if (i_mem_rdata !== exp_i_rdata) begin
      n_fail++; $display("FAIL i_only_rdata: got %h expected %h", i_mem_rdata, exp_i_rdata);
    end
    @(negedge clk);
    n_checks++;
    if ({i_mem_ready, d_mem_ready} !== 2'b00 || dbg_state !== 2'd0) begin
      n_fail++; $display("FAIL i_only_after: got ready %b state %0d expected 00 0", {i_mem_ready, d_mem_ready}, dbg_state);
    end
  endtask

  task automatic test_simultaneous();
    logic [DW-1:0] rdi = 128'h11111111_22222222_33333333_44444444;
    logic [DW-1:0] rdd = 128'hAAAAAAAA_BBBBBBBB_CCCCCCCC_DDDDDDDD;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_i_rdata = '0; exp_d_rdata = '0;
    i_mem_addr = 28'h1111111; d_mem_addr = 28'h2222222;
    i_mem_read = 1'b1; d_mem_read = 1'b1;
    mem_respond(2, rdi);
    i_mem_read = 1'b0;
    exp_i_rdata = rdi;
    n_checks++;
    if (o_to || o_addr !== 28'h1111111 || o_gap != 0) begin
      n_fail++; $display("FAIL sim_first_grant: got addr %h gap %0d expected 1111111 0", o_addr, o_gap);
    end
    n_checks++;
    if ({i_mem_ready, d_mem_ready} !== 2'b10 || i_mem_rdata !== exp_i_rdata || d_mem_rdata !== exp_d_rdata) begin
      n_fail++; $display("FAIL sim_first_resp: got ready %b i %h d %h expected 10 %h %h", {i_mem_ready, d_mem_ready}, i_mem_rdata, d_mem_rdata, exp_i_rdata, exp_d_rdata);
    end
    mem_respond(1, rdd);
    d_mem_read = 1'b0;
    exp_d_rdata = rdd;
    n_checks++;
    if (o_to || o_addr !== 28'h2222222 || o_gap != 1) begin
      n_fail++; $display("FAIL sim_second_grant: got addr %h gap %0d expected 2222222 1", o_addr, o_gap);
    end
    n_checks++;
    if ({i_mem_ready, d_mem_ready} !== 2'b01 || i_mem_rdata !== exp_i_rdata || d_mem_rdata !== exp_d_rdata) begin
      n_fail++; $display("FAIL sim_second_resp: got ready %b i %h d %h expected 01 %h %h", {i_mem_ready, d_mem_ready}, i_mem_rdata, d_mem_rdata, exp_i_rdata, exp_d_rdata);
    end
    @(negedge clk);
  endtask

  task automatic test_fairness();
    logic [DW-1:0] rd;
    logic [AW-1:0] ea;
    bit            i_turn;
    i_mem_addr = 28'h0000100; d_mem_addr = 28'h0000200;
    for (int k = 0; k < 8; k++) exp_q.push_back((k % 2 == 0) ? 28'h0000100 : 28'h0000200);
    i_mem_read = 1'b1; d_mem_read = 1'b1;
    for (int k = 0; k < 8; k++) begin
      rd = {96'h0, 32'hA0000000 + 32'(k)};
      mem_respond(1, rd);
      ea = exp_q.pop_front();
      i_turn = (ea == 28'h0000100);
      if (i_turn) exp_i_rdata = rd; else exp_d_rdata = rd;
      n_checks++;
      if (o_to || o_addr !== ea || o_gap != 0) begin
        n_fail++; $display("FAIL fair_grant_%0d: got addr %h gap %0d expected %h 0", k, o_addr, o_gap, ea);
      end
      n_checks++;
      if ({i_mem_ready, d_mem_ready} !== {i_turn, ~i_turn} || i_mem_rdata !== exp_i_rdata || d_mem_rdata !== exp_d_rdata) begin
        n_fail++; $display("FAIL fair_resp_%0d: got ready %b i %h d %h expected %b %h %h", k, {i_mem_ready, d_mem_ready}, i_mem_rdata, d_mem_rdata, {i_turn, ~i_turn}, exp_i_rdata, exp_d_rdata);
      end
      if (i_turn) i_mem_read = 1'b0; else d_mem_read = 1'b0;
      if (k == 7) begin
        i_mem_read = 1'b0; d_mem_read = 1'b0;
      end
      @(negedge clk);
      if (k != 7) begin
        if (i_turn) i_mem_read = 1'b1; else d_mem_read = 1'b1;
      end
    end
  endtask

  task automatic test_d_write();
    logic [DW-1:0] wd = 128'h0123456789ABCDEF_0123456789ABCDEF;
    d_mem_addr = 28'h0ABCDEF; d_mem_wdata = wd; d_mem_write = 1'b1;
    mem_respond(2, {DW{1'b1}});
    d_mem_write = 1'b0;
    n_checks++;
    if (o_to || o_nwr != 2 || o_nrd != 0 || !o_stable) begin
      n_fail++; $display("FAIL wr_strobe: got to=%0d wr=%0d rd=%0d stable=%0d expected 0 2 0 1", o_to, o_nwr, o_nrd, o_stable);
    end
    n_checks++;
    if (o_addr !== 28'h0ABCDEF || o_wdata !== wd) begin
      n_fail++; $display("FAIL wr_line: got addr %h data %h expected 0abcdef %h", o_addr, o_wdata, wd);
    end
    n_checks++;
    if ({i_mem_ready, d_mem_ready, mem_write} !== 3'b010 || d_mem_rdata !== exp_d_rdata) begin
      n_fail++; $display("FAIL wr_resp: got i/d/wr %b rdata %h expected 010 %h", {i_mem_ready, d_mem_ready, mem_write}, d_mem_rdata, exp_d_rdata);
    end
    @(negedge clk);
    n_checks++;
    if (d_mem_ready !== 1'b0) begin
      n_fail++; $display("FAIL wr_single_pulse: got %b expected 0", d_mem_ready);
    end
  endtask

  task automatic test_rw_conflict();
    logic [DW-1:0] wd = 128'hFEEDFACE_CAFEF00D_0BADC0DE_55AA55AA;
    int pulses = 0;
    d_mem_addr = 28'h0000ABC; d_mem_wdata = wd;
    d_mem_read = 1'b1; d_mem_write = 1'b1;
    mem_respond(1, 128'h5555_0000_5555_0000_5555_0000_5555_0000);
    d_mem_read = 1'b0; d_mem_write = 1'b0;
    n_checks++;
    if (o_to || o_nwr != 1 || o_nrd != 0 || o_wdata !== wd || o_addr !== 28'h0000ABC) begin
      n_fail++; $display("FAIL rw_op: got wr=%0d rd=%0d data %h addr %h expected 1 0 %h 0000abc", o_nwr, o_nrd, o_wdata, o_addr, wd);
    end
    n_checks++;
    if (d_mem_ready !== 1'b1 || d_mem_rdata !== exp_d_rdata) begin
      n_fail++; $display("FAIL rw_resp: got ready %b rdata %h expected 1 %h", d_mem_ready, d_mem_rdata, exp_d_rdata);
    end
    repeat (3) begin
      @(negedge clk);
      if (d_mem_ready || i_mem_ready || mem_read || mem_write) pulses++;
    end
    n_checks++;
    if (pulses != 0) begin
      n_fail++; $display("FAIL rw_extra_activity: got %0d cycles expected 0", pulses);
    end
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] rd = 128'h0F0F0F0F_F0F0F0F0_12345678_9ABCDEF0;
    int activity = 0;
    i_mem_addr = 28'h0000333; i_mem_read = 1'b1;
    @(negedge clk);
    n_checks++;
    if (mem_read !== 1'b1 || mem_addr !== 28'h0000333) begin
      n_fail++; $display("FAIL mid_busy: got rd %b addr %h expected 1 0000333", mem_read, mem_addr);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({mem_read, mem_write, i_mem_ready, d_mem_ready} !== 4'b0000 || mem_addr !== 28'h0 || dbg_state !== 2'd0) begin
      n_fail++; $display("FAIL mid_async_clear: got %b addr %h state %0d expected 0000 0 0", {mem_read, mem_write, i_mem_ready, d_mem_ready}, mem_addr, dbg_state);
    end
    n_checks++;
    if (i_mem_rdata !== 128'h0 || d_mem_rdata !== 128'h0) begin
      n_fail++; $display("FAIL mid_rdata_clear: got i %h d %h expected 0", i_mem_rdata, d_mem_rdata);
    end
    exp_i_rdata = '0; exp_d_rdata = '0;
    i_mem_read = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (i_mem_ready || d_mem_ready || mem_read || mem_write) activity++;
    end
    n_checks++;
    if (activity != 0) begin
      n_fail++; $display("FAIL mid_no_ready: got %0d active cycles expected 0", activity);
    end
    i_mem_addr = 28'h0000444; i_mem_read = 1'b1;
    mem_respond(2, rd);
    i_mem_read = 1'b0;
    exp_i_rdata = rd;
    n_checks++;
    if (o_to || o_nrd != 2 || o_addr !== 28'h0000444 || i_mem_ready !== 1'b1 || i_mem_rdata !== exp_i_rdata) begin
      n_fail++; $display("FAIL mid_fresh_txn: got rd=%0d addr %h ready %b rdata %h expected 2 0000444 1 %h", o_nrd, o_addr, i_mem_ready, i_mem_rdata, exp_i_rdata);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_i_only();
    test_simultaneous();
    test_fairness();
    test_d_write();
    test_rw_conflict();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
